// File: rtl/rs_issue_scheduler.sv
// rtl/rs_issue_scheduler.sv - reservation station with CDB wake-up and oldest-ready issue
module rs_issue_scheduler #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [82:0]                disp_inst,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [31:0]                cdb_value,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [82:0]                issue_inst,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] ent_valid;
    logic [82:0]      ent_data [DEPTH];
    logic [CW-1:0]    occ_q;

    logic [DEPTH-1:0] nxt_valid;
    logic [82:0]      nxt_data [DEPTH];
    logic [CW-1:0]    nxt_occ;
    logic [DEPTH:0]   ext_valid;
    logic [82:0]      ext_data [DEPTH+1];

    logic             sel_found;
    logic [IW-1:0]    sel_idx;
    logic             issue_fire;
    logic             disp_fire;
    logic [CW-1:0]    wr_idx;

    // Capture a broadcast result into whichever operands are still waiting on its tag.
    function automatic logic [82:0] wake(input logic [82:0] p, input logic cv,
                                         input logic [TAG_W-1:0] tag, input logic [31:0] val);
        logic [82:0] r;
        r = p;
        if (cv && !p[17] && (p[18 +: TAG_W] == tag)) begin
            r[49:18] = val;
            r[17]    = 1'b1;
        end
        if (cv && !p[50] && (p[51 +: TAG_W] == tag)) begin
            r[82:51] = val;
            r[50]    = 1'b1;
        end
        return r;
    endfunction

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!sel_found && ent_valid[i] && ent_data[i][17] && ent_data[i][50]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
        end
    end

    assign issue_valid = sel_found;
    assign issue_inst  = sel_found ? ent_data[sel_idx] : '0;
    assign disp_ready  = (occ_q < CW'(DEPTH));
    assign occupancy   = occ_q;
    assign issue_fire  = issue_valid & issue_ready;
    assign disp_fire   = disp_valid & disp_ready;
    assign wr_idx      = occ_q - CW'(issue_fire);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ext_valid[i] = ent_valid[i];
            ext_data[i]  = ent_data[i];
        end
        ext_valid[DEPTH] = 1'b0;
        ext_data[DEPTH]  = '0;

        for (int i = 0; i < DEPTH; i++) begin
            // Entries at and above the issued slot move down one to keep age order.
            if (issue_fire && (IW'(i) >= sel_idx)) begin
                nxt_valid[i] = ext_valid[i+1];
                nxt_data[i]  = ext_valid[i+1] ? wake(ext_data[i+1], cdb_valid, cdb_tag, cdb_value) : '0;
            end else begin
                nxt_valid[i] = ext_valid[i];
                nxt_data[i]  = ext_valid[i] ? wake(ext_data[i], cdb_valid, cdb_tag, cdb_value) : '0;
            end
            if (disp_fire && (CW'(i) == wr_idx)) begin
                nxt_valid[i] = 1'b1;
                nxt_data[i]  = wake(disp_inst, cdb_valid, cdb_tag, cdb_value);
            end
            if (flush) begin
                nxt_valid[i] = 1'b0;
                nxt_data[i]  = '0;
            end
        end

        nxt_occ = occ_q + CW'(disp_fire) - CW'(issue_fire);
        if (flush) begin
            nxt_occ = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q     <= '0;
            ent_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_data[i] <= '0;
            end
        end else begin
            occ_q     <= nxt_occ;
            ent_valid <= nxt_valid;
            for (int i = 0; i < DEPTH; i++) begin
                ent_data[i] <= nxt_data[i];
            end
        end
    end
endmodule

// File: tb/tb_rs_issue_scheduler.sv
// tb/tb_rs_issue_scheduler.sv - directed table-driven bench for rs_issue_scheduler
module tb_rs_issue_scheduler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        disp_valid = 1'b0;
    logic        disp_ready;
    logic [82:0] disp_inst = '0;
    logic        cdb_valid = 1'b0;
    logic [5:0]  cdb_tag = '0;
    logic [31:0] cdb_value = '0;
    logic        issue_valid;
    logic        issue_ready = 1'b0;
    logic [82:0] issue_inst;
    logic [2:0]  occupancy;

    int checks = 0;
    int errors = 0;

    rs_issue_scheduler #(.DEPTH(4), .TAG_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_inst(disp_inst),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_inst(issue_inst),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        dv;
        logic [82:0] di;
        logic        cv;
        logic [5:0]  ct;
        logic [31:0] cval;
        logic        ir;
        logic [2:0]  occ;
        logic        iv;
        logic [82:0] inst;
        logic        dr;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [82:0] mk(input logic [31:0] rs2, input logic s2v, input logic [31:0] rs1,
                                       input logic s1v, input logic [4:0] rd, input logic [11:0] ctrl);
        return {rs2, s2v, rs1, s1v, rd, ctrl};
    endfunction

    function automatic logic [31:0] tg(input logic [5:0] t);
        return {26'd0, t};
    endfunction

    task automatic add(input logic dv, input logic [82:0] di, input logic cv, input logic [5:0] ct,
                       input logic [31:0] cval, input logic ir, input logic [2:0] occ, input logic iv,
                       input logic [82:0] inst, input logic dr);
        vec_t v;
        v.dv = dv; v.di = di; v.cv = cv; v.ct = ct; v.cval = cval; v.ir = ir;
        v.occ = occ; v.iv = iv; v.inst = inst; v.dr = dr;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [82:0] act, input logic [82:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tagname, input logic [2:0] occ, input logic iv,
                            input logic [82:0] inst, input logic dr);
        chk({tagname, " occupancy"}, 83'(occupancy), 83'(occ));
        chk({tagname, " issue_valid"}, 83'(issue_valid), 83'(iv));
        chk({tagname, " issue_inst"}, issue_inst, inst);
        chk({tagname, " disp_ready"}, 83'(disp_ready), 83'(dr));
    endtask

    task automatic drive(input logic dv, input logic [82:0] di, input logic ir, input logic fl);
        disp_valid = dv; disp_inst = di; issue_ready = ir; flush = fl;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
    endtask

    logic [82:0] a, b, b_rdy, c, c_rdy, d, e, e_rdy, g, h, h_rdy, z;
    logic [82:0] f [5];

    initial begin
        z     = '0;
        a     = mk(32'h11, 1'b1, 32'h22, 1'b1, 5'd5, 12'h001);
        b     = mk(32'h33, 1'b1, tg(6'h0A), 1'b0, 5'd7, 12'h002);
        b_rdy = mk(32'h33, 1'b1, 32'h1234_5678, 1'b1, 5'd7, 12'h002);
        c     = mk(32'h44, 1'b1, tg(6'h03), 1'b0, 5'd8, 12'h003);
        c_rdy = mk(32'h44, 1'b1, 32'h0000_CAFE, 1'b1, 5'd8, 12'h003);
        d     = mk(32'h55, 1'b1, 32'h66, 1'b1, 5'd9, 12'h004);
        e     = mk(tg(6'h11), 1'b0, 32'h77, 1'b1, 5'd10, 12'h005);
        e_rdy = mk(32'hFFFF_0000, 1'b1, 32'h77, 1'b1, 5'd10, 12'h005);
        g     = mk(32'h99, 1'b1, 32'h98, 1'b1, 5'd20, 12'h0A0);
        h     = mk(tg(6'h21), 1'b0, tg(6'h21), 1'b0, 5'd21, 12'h0B0);
        h_rdy = mk(32'h0000_ABCD, 1'b1, 32'h0000_ABCD, 1'b1, 5'd21, 12'h0B0);
        for (int k = 0; k < 5; k++) begin
            f[k] = mk(32'h100 + 32'(k), 1'b1, 32'h200 + 32'(k), 1'b1, 5'(k), 12'h010 + 12'(k));
        end

        // expected outputs are the pre-edge values seen while the row's inputs are applied
        add(0, z, 0, 0, 0, 0, 3'd0, 0, z, 1);
        add(1, a, 0, 0, 0, 1, 3'd0, 0, z, 1);
        add(0, z, 0, 0, 0, 1, 3'd1, 1, a, 1);
        add(0, z, 0, 0, 0, 1, 3'd0, 0, z, 1);
        add(1, b, 0, 0, 0, 1, 3'd0, 0, z, 1);
        add(0, z, 0, 0, 0, 1, 3'd1, 0, z, 1);
        add(0, z, 1, 6'h0A, 32'h1234_5678, 1, 3'd1, 0, z, 1);
        add(0, z, 0, 0, 0, 1, 3'd1, 1, b_rdy, 1);
        add(0, z, 0, 0, 0, 1, 3'd0, 0, z, 1);
        add(1, c, 0, 0, 0, 1, 3'd0, 0, z, 1);
        add(1, d, 0, 0, 0, 1, 3'd1, 0, z, 1);
        add(0, z, 0, 0, 0, 1, 3'd2, 1, d, 1);
        add(0, z, 1, 6'h03, 32'h0000_CAFE, 1, 3'd1, 0, z, 1);
        add(0, z, 0, 0, 0, 1, 3'd1, 1, c_rdy, 1);
        add(0, z, 0, 0, 0, 1, 3'd0, 0, z, 1);
        add(1, f[0], 0, 0, 0, 0, 3'd0, 0, z, 1);
        add(1, f[1], 0, 0, 0, 0, 3'd1, 1, f[0], 1);
        add(1, f[2], 0, 0, 0, 0, 3'd2, 1, f[0], 1);
        add(1, f[3], 0, 0, 0, 0, 3'd3, 1, f[0], 1);
        add(1, f[4], 0, 0, 0, 0, 3'd4, 1, f[0], 0);
        add(1, f[4], 0, 0, 0, 1, 3'd4, 1, f[0], 0);
        add(1, g, 0, 0, 0, 1, 3'd3, 1, f[1], 1);
        add(0, z, 0, 0, 0, 1, 3'd3, 1, f[2], 1);
        add(0, z, 0, 0, 0, 1, 3'd2, 1, f[3], 1);
        add(0, z, 0, 0, 0, 1, 3'd1, 1, g, 1);
        add(0, z, 0, 0, 0, 0, 3'd0, 0, z, 1);
        add(1, e, 1, 6'h11, 32'hFFFF_0000, 1, 3'd0, 0, z, 1);
        add(0, z, 0, 0, 0, 1, 3'd1, 1, e_rdy, 1);
        add(0, z, 0, 0, 0, 1, 3'd0, 0, z, 1);
        add(1, h, 0, 0, 0, 1, 3'd0, 0, z, 1);
        add(0, z, 1, 6'h21, 32'h0000_ABCD, 1, 3'd1, 0, z, 1);
        add(0, z, 0, 0, 0, 1, 3'd1, 1, h_rdy, 1);
        add(0, z, 0, 0, 0, 0, 3'd0, 0, z, 1);

        repeat (2) @(negedge clk);
        chk_outs("in_reset", 3'd0, 1'b0, z, 1'b1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int r = 0; r < vecs.size(); r++) begin
            disp_valid = vecs[r].dv; disp_inst = vecs[r].di;
            cdb_valid = vecs[r].cv; cdb_tag = vecs[r].ct; cdb_value = vecs[r].cval;
            issue_ready = vecs[r].ir; flush = 1'b0;
            @(negedge clk);
            chk_outs($sformatf("row%0d", r), vecs[r].occ, vecs[r].iv, vecs[r].inst, vecs[r].dr);
            @(posedge clk); #1;
        end

        // flush with three entries held, a pending dispatch and a live issue handshake
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, f[k], 1'b0, 1'b0);
            @(posedge clk); #1;
        end
        drive(1'b1, f[3], 1'b1, 1'b1);
        @(negedge clk);
        chk_outs("pre_flush", 3'd3, 1'b1, f[0], 1'b1);
        @(posedge clk); #1;
        drive(1'b0, z, 1'b0, 1'b0);
        @(negedge clk);
        chk_outs("post_flush", 3'd0, 1'b0, z, 1'b1);
        @(posedge clk); #1;

        // asynchronous reset mid-stream clears without a clock edge
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, f[k], 1'b0, 1'b0);
            @(posedge clk); #1;
        end
        drive(1'b0, z, 1'b0, 1'b0);
        @(negedge clk);
        chk_outs("pre_rst", 3'd2, 1'b1, f[0], 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk_outs("async_rst", 3'd0, 1'b0, z, 1'b1);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk_outs("after_rst", 3'd0, 1'b0, z, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
